crc_frame_serializer: RTL and testbench

Downstream stage of the 4-level pipelined CRC generator. It queues each 10-bit message and pairs it with the 9-bit CRC word the pipeline later produces. It forms the 19-bit codeword {msg, crc} and shifts it out MSB-first on a 1-bit valid/ready serial link, marking each frame with a start-of-frame flag. The CRC pipeline cannot stall, so CRC words are always accepted; only the message side is back-pressured.

---
 rtl/crc_pkg.sv | 17 +
 rtl/crc_frame_serializer_if.sv | 33 +++
 rtl/crc_pair_fifo.sv | 99 +++++++++
 rtl/crc_frame_serializer.sv | 92 +++++++++
 tb/tb_crc_frame_serializer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared constants and types for the CRC generator and its frame serializer.
//   MSG_W   : message width fed to the CRC pipeline
//   CRC_W   : CRC word width produced by the pipeline
//   FRAME_W : serialized codeword width {msg, crc}
//   state_t : serializer FSM states
package crc_pkg;

  localparam int MSG_W   = 10;
  localparam int CRC_W   = 9;
  localparam int FRAME_W = MSG_W + CRC_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Bus bundle for crc_frame_serializer.
//   msg_valid/msg_ready/msg : back-pressured message input
//   crc_valid/crc           : CRC word pulse from the pipeline (never stalled)
//   ser_data/ser_sof/ser_valid/ser_ready : 1-bit serial output link
//   busy/orphan_err         : status
// master : the side that feeds messages/CRCs and sinks the serial link
// slave  : the serializer
interface crc_frame_serializer_if;
  import crc_pkg::*;

  logic             msg_valid;
  logic             msg_ready;
  logic [MSG_W-1:0] msg;
  logic             crc_valid;
  logic [CRC_W-1:0] crc;
  logic             ser_data;
  logic             ser_sof;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             orphan_err;

  modport master (
    output msg_valid, msg, crc_valid, crc, ser_ready,
    input  msg_ready, ser_data, ser_sof, ser_valid, busy, orphan_err
  );

  modport slave (
    input  msg_valid, msg, crc_valid, crc, ser_ready,
    output msg_ready, ser_data, ser_sof, ser_valid, busy, orphan_err
  );

endinterface

// File: rtl/crc_pair_fifo.sv
// Message queue that pairs each queued message with the CRC word that the
// pipeline delivers later, in order.
//   clk, reset  : clock, asynchronous active-low reset
//   push        : message offered (accepted only when msg_ready)
//   push_msg    : message word
//   crc_valid   : CRC word strobe; crc : CRC word
//   pop         : consume head entry (only asserted when head_rdy)
//   msg_ready   : queue not full (registered count only)
//   head_rdy    : head entry exists and is paired
//   not_empty   : count != 0
//   head_msg/head_crc : head entry contents
//   orphan_err  : sticky, CRC arrived with no unpaired message
module crc_pair_fifo
  import crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [MSG_W-1:0] push_msg,
  input  logic             crc_valid,
  input  logic [CRC_W-1:0] crc,
  input  logic             pop,
  output logic             msg_ready,
  output logic             head_rdy,
  output logic             not_empty,
  output logic [MSG_W-1:0] head_msg,
  output logic [CRC_W-1:0] head_crc,
  output logic             orphan_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [MSG_W-1:0] msg_mem [DEPTH];
  logic [CRC_W-1:0] crc_mem [DEPTH];
  logic [DEPTH-1:0] paired;

  // wr_ptr/pair_ptr carry an extra wrap bit so "all unpaired" and
  // "all paired" are distinguishable when the queue is full.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] pair_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;

  logic accept;
  logic pair_hit;

  assign msg_ready = (count != PW'(DEPTH));
  assign not_empty = (count != '0);
  assign accept    = push && msg_ready;
  // Only entries pushed on earlier edges are visible to pairing.
  assign pair_hit  = crc_valid && (pair_ptr != wr_ptr);
  assign head_rdy  = not_empty && paired[rd_ptr];
  assign head_msg  = msg_mem[rd_ptr];
  assign head_crc  = crc_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      pair_ptr   <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      paired     <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (accept) begin
        paired[wr_ptr[AW-1:0]] <= 1'b0;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pair_hit) begin
        paired[pair_ptr[AW-1:0]] <= 1'b1;
        pair_ptr                 <= pair_ptr + 1'b1;
      end else if (crc_valid) begin
        orphan_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only read after a fresh push.
  always_ff @(posedge clk) begin
    if (accept) begin
      msg_mem[wr_ptr[AW-1:0]] <= push_msg;
    end
    if (pair_hit) begin
      crc_mem[pair_ptr[AW-1:0]] <= crc;
    end
  end

endmodule

// File: rtl/crc_frame_serializer.sv
// Pairs queued messages with their CRC words and shifts the 19-bit codeword
// {msg, crc} out MSB-first on a 1-bit valid/ready link, flagging the first
// bit of each frame with ser_sof. Back-to-back frames have no idle cycle.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : crc_frame_serializer_if.slave (message, CRC, serial, status)
module crc_frame_serializer
  import crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  crc_frame_serializer_if.slave   bus
);

  localparam int CW = $clog2(FRAME_W);

  state_t             state;
  logic [CW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] shreg;

  logic             head_rdy;
  logic             not_empty;
  logic [MSG_W-1:0] head_msg;
  logic [CRC_W-1:0] head_crc;
  logic             last_bit;
  logic             shift_en;
  logic             load;

  crc_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.msg_valid),
    .push_msg   (bus.msg),
    .crc_valid  (bus.crc_valid),
    .crc        (bus.crc),
    .pop        (load),
    .msg_ready  (bus.msg_ready),
    .head_rdy   (head_rdy),
    .not_empty  (not_empty),
    .head_msg   (head_msg),
    .head_crc   (head_crc),
    .orphan_err (bus.orphan_err)
  );

  assign shift_en = (state == SHIFT) && bus.ser_ready;
  assign last_bit = (bit_cnt == CW'(FRAME_W - 1));
  // Load (and pop) from IDLE, or on the final bit's handshake for zero-gap.
  assign load     = head_rdy && ((state == IDLE) || (shift_en && last_bit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (load) begin
          state   <= SHIFT;
          bit_cnt <= '0;
        end
      end else if (shift_en) begin
        if (last_bit) begin
          bit_cnt <= '0;
          if (!head_rdy) begin
            state <= IDLE;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Shift register is datapath only; outputs are gated by state so stale
  // contents after reset are never visible.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= {head_msg, head_crc};
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_W-2:0], 1'b0};
    end
  end

  assign bus.ser_valid = (state == SHIFT);
  assign bus.ser_data  = (state == SHIFT) && shreg[FRAME_W-1];
  assign bus.ser_sof   = (state == SHIFT) && (bit_cnt == '0);
  assign bus.busy      = not_empty || (state == SHIFT);

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Scoreboard bench for crc_frame_serializer: each paired CRC pushes its 19
// expected {sof, data} bits; the monitor pops and compares on every accepted
// serial bit.
module tb_crc_frame_serializer;
  import crc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  crc_frame_serializer_if bus ();

  crc_frame_serializer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] sb [$];
  int         rx_bits = 0;
  int         vld_cycles = 0;
  int         cyc = 0;
  int         first_v = -1;
  int         last_v = -1;
  bit         was_stall = 1'b0;
  logic [1:0] held = 2'b00;
  logic [1:0] mon_exp;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_frame(input logic [MSG_W-1:0] m, input logic [CRC_W-1:0] c);
    logic [FRAME_W-1:0] f;
    f = {m, c};
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      sb.push_back({(i == FRAME_W - 1), f[i]});
    end
  endtask

  task automatic push_msg(input logic [MSG_W-1:0] m);
    bus.msg_valid = 1'b1;
    bus.msg       = m;
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
  endtask

  task automatic send_crc(input logic [CRC_W-1:0] c, input logic [MSG_W-1:0] m,
                          input bit expect_frame);
    bus.crc_valid = 1'b1;
    bus.crc       = c;
    if (expect_frame) exp_frame(m, c);
    @(posedge clk);
    #1;
    bus.crc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && sb.size() == 0) break;
    end
    chk("drain_busy", int'(bus.busy), 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  // Monitor: compare every accepted bit, and check hold-stability on stalls.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (was_stall) begin
        chk("stall_valid", int'(bus.ser_valid), 1);
        chk("stall_data", int'(bus.ser_data), int'(held[0]));
        chk("stall_sof", int'(bus.ser_sof), int'(held[1]));
      end
      was_stall = bus.ser_valid && !bus.ser_ready;
      held      = {bus.ser_sof, bus.ser_data};
      if (bus.ser_valid) begin
        vld_cycles++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.ser_valid && bus.ser_ready) begin
        rx_bits++;
        if (sb.size() == 0) begin
          chk("extra_bit", int'(bus.ser_valid), 0);
        end else begin
          mon_exp = sb.pop_front();
          chk("ser_data", int'(bus.ser_data), int'(mon_exp[0]));
          chk("ser_sof", int'(bus.ser_sof), int'(mon_exp[1]));
        end
      end
    end else begin
      was_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.msg_valid = 1'b0;
    bus.msg       = '0;
    bus.crc_valid = 1'b0;
    bus.crc       = '0;
    bus.ser_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ser_valid", int'(bus.ser_valid), 0);
    chk("rst_ser_sof", int'(bus.ser_sof), 0);
    chk("rst_ser_data", int'(bus.ser_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_orphan", int'(bus.orphan_err), 0);
    chk("rst_msg_ready", int'(bus.msg_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frame with latency check
    push_msg(10'h303);
    @(posedge clk);
    #1;
    send_crc(9'h0A5, 10'h303, 1'b1);
    @(negedge clk);
    chk("lat_not_yet", int'(bus.ser_valid), 0);
    @(negedge clk);
    chk("lat_valid", int'(bus.ser_valid), 1);
    chk("lat_sof", int'(bus.ser_sof), 1);
    chk("lat_msb", int'(bus.ser_data), 1);
    wait_idle(60);

    // Back-to-back frames
    vld_cycles = 0;
    first_v    = -1;
    last_v     = -1;
    push_msg(10'h303);
    push_msg(10'h155);
    push_msg(10'h000);
    send_crc(9'h0A5, 10'h303, 1'b1);
    send_crc(9'h1FF, 10'h155, 1'b1);
    send_crc(9'h001, 10'h000, 1'b1);
    wait_idle(120);
    chk("b2b_valid_cycles", vld_cycles, 57);
    chk("b2b_span", last_v - first_v + 1, 57);

    // Full queue
    push_msg(10'h001);
    push_msg(10'h2AA);
    push_msg(10'h155);
    push_msg(10'h3C3);
    chk("full_ready_low", int'(bus.msg_ready), 0);
    bus.msg_valid = 1'b1;
    bus.msg       = 10'h3FF;
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
    chk("full_ready_still_low", int'(bus.msg_ready), 0);
    chk("full_busy", int'(bus.busy), 1);
    send_crc(9'h100, 10'h001, 1'b1);
    @(negedge clk);
    chk("full_ready_before_pop", int'(bus.msg_ready), 0);
    @(negedge clk);
    chk("full_ready_after_pop", int'(bus.msg_ready), 1);
    send_crc(9'h0FF, 10'h2AA, 1'b1);
    send_crc(9'h055, 10'h155, 1'b1);
    send_crc(9'h1AB, 10'h3C3, 1'b1);
    wait_idle(150);

    // Orphan CRC
    send_crc(9'h077, 10'h000, 1'b0);
    @(negedge clk);
    chk("orphan_set", int'(bus.orphan_err), 1);
    push_msg(10'h12A);
    send_crc(9'h033, 10'h12A, 1'b1);
    wait_idle(60);
    chk("orphan_sticky", int'(bus.orphan_err), 1);

    // Random sink stalls
    push_msg(10'h303);
    send_crc(9'h0A5, 10'h303, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      bus.ser_ready = 1'($urandom_range(0, 1));
      if (!bus.busy && sb.size() == 0) break;
    end
    bus.ser_ready = 1'b1;
    wait_idle(60);

    // Reset mid-frame at bit 7
    base = rx_bits;
    push_msg(10'h303);
    send_crc(9'h0A5, 10'h303, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rx_bits - base >= 7) break;
    end
    chk("rst_bit7_reached", rx_bits - base, 7);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", int'(bus.ser_valid), 0);
    chk("mid_rst_sof", int'(bus.ser_sof), 0);
    chk("mid_rst_data", int'(bus.ser_data), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_ready", int'(bus.msg_ready), 1);
    chk("mid_rst_orphan", int'(bus.orphan_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    vld_cycles = 0;
    repeat (30) @(negedge clk);
    chk("post_rst_quiet", vld_cycles, 0);
    push_msg(10'h155);
    send_crc(9'h1FF, 10'h155, 1'b1);
    wait_idle(60);
    chk("post_rst_frame_bits", vld_cycles, 19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
